// File: rtl/sub_result_stage.sv
// rtl/sub_result_stage.sv - registered subtract result stage with clamp, 2-deep buffer and counters
module sub_result_stage #(
    parameter int WIDTH    = 64,
    parameter int CNT_W    = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_diff,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] ovf_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             pop;
    logic             load_head;
    logic             load_skid;
    logic             skid_to_head;
    logic [WIDTH-1:0] in_fin;

    logic [WIDTH-1:0] head_diff;
    logic             head_ovf;
    logic             head_zero;
    logic             head_neg;
    logic [WIDTH-1:0] skid_diff;
    logic             skid_ovf;

    logic [CNT_W-1:0] beat_q;
    logic [CNT_W-1:0] ovf_q;

    // Handshake flags come straight from the state register so in_ready never sees out_ready.
    assign in_ready  = (state != S_TWO);
    assign out_valid = (state != S_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Clamp is applied before storage so the flags describe the value actually presented.
    always_comb begin
        in_fin = in_diff;
        if (SATURATE && in_ovf) begin
            in_fin = in_diff[WIDTH-1] ? SMAX : SMIN;
        end
    end

    always_comb begin
        state_nx     = state;
        load_head    = 1'b0;
        load_skid    = 1'b0;
        skid_to_head = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nx  = S_ONE;
                    load_head = 1'b1;
                end
            end
            S_ONE: begin
                case ({accept, pop})
                    2'b10: begin
                        state_nx  = S_TWO;
                        load_skid = 1'b1;
                    end
                    2'b01: state_nx = S_EMPTY;
                    2'b11: load_head = 1'b1;
                    default: state_nx = S_ONE;
                endcase
            end
            S_TWO: begin
                if (pop) begin
                    state_nx     = S_ONE;
                    skid_to_head = 1'b1;
                end
            end
            default: state_nx = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_diff <= '0;
            head_ovf  <= 1'b0;
            head_zero <= 1'b0;
            head_neg  <= 1'b0;
            skid_diff <= '0;
            skid_ovf  <= 1'b0;
        end else begin
            if (load_head) begin
                head_diff <= in_fin;
                head_ovf  <= in_ovf;
                head_zero <= (in_fin == '0);
                head_neg  <= in_fin[WIDTH-1];
            end else if (skid_to_head) begin
                head_diff <= skid_diff;
                head_ovf  <= skid_ovf;
                head_zero <= (skid_diff == '0);
                head_neg  <= skid_diff[WIDTH-1];
            end
            if (load_skid) begin
                skid_diff <= in_fin;
                skid_ovf  <= in_ovf;
            end
        end
    end

    // Saturating counters; a clear in the same cycle as an accept takes priority.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            beat_q <= '0;
            ovf_q  <= '0;
        end else if (accept) begin
            if (!(&beat_q)) begin
                beat_q <= beat_q + CNT_W'(1);
            end
            if (in_ovf && !(&ovf_q)) begin
                ovf_q <= ovf_q + CNT_W'(1);
            end
        end
    end

    assign out_diff = head_diff;
    assign out_ovf  = head_ovf;
    assign out_zero = head_zero;
    assign out_neg  = head_neg;
    assign beat_cnt = beat_q;
    assign ovf_cnt  = ovf_q;

endmodule
